// File: rtl/regfile_writer.sv
// Write-back sequencer: merges ALU and buffered load results onto the
// register file write port and tracks in-flight destinations.
module regfile_writer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [WIDTH-1:0] alu_val,
  input  logic             ld_valid,
  output logic             ld_ready,
  input  logic [4:0]       ld_rd,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  input  logic [4:0]       rs1_q,
  input  logic [4:0]       rs2_q,
  input  logic [4:0]       rd_q,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             rd_busy,
  output logic             w_enable,
  output logic [4:0]       rd_select,
  output logic [WIDTH-1:0] w_val
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [4:0]       rd;
    logic [WIDTH-1:0] val;
  } wb_t;

  wb_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   busy;
  logic [31:0]   busy_nxt;
  logic          push;
  logic          pop;
  logic          sel_vld;
  logic          do_wr;
  wb_t           sel;

  // Full FIFO refuses pushes even while popping.
  assign ld_ready = (count != CW'(DEPTH));
  assign push     = ld_valid && ld_ready;

  always_comb begin
    sel_vld = 1'b0;
    pop     = 1'b0;
    sel     = '0;
    priority case (1'b1)
      alu_valid: begin
        sel_vld = 1'b1;
        sel     = '{rd: alu_rd, val: alu_val};
      end
      (count != '0): begin
        sel_vld = 1'b1;
        pop     = 1'b1;
        sel     = mem[rd_ptr];
      end
      default: ;
    endcase
  end

  assign do_wr = sel_vld && (sel.rd != 5'd0);

  // Set after clear so a new producer supersedes a retiring one.
  always_comb begin
    busy_nxt = busy;
    if (sel_vld)
      busy_nxt[sel.rd] = 1'b0;
    if (iss_valid)
      busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{rd: ld_rd, val: ld_val};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      busy      <= '0;
      w_enable  <= 1'b0;
      rd_select <= '0;
      w_val     <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      busy     <= busy_nxt;
      w_enable <= do_wr;
      if (do_wr) begin
        rd_select <= sel.rd;
        w_val     <= sel.val;
      end
    end
  end

  assign rs1_busy = busy[rs1_q];
  assign rs2_busy = busy[rs2_q];
  assign rd_busy  = busy[rd_q];

endmodule

// File: tb/tb_regfile_writer.sv
// Randomized and directed bench for regfile_writer against a
// queue-based reference model.
module tb_regfile_writer;

  localparam int W = 32;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         alu_valid;
  logic [4:0]   alu_rd;
  logic [W-1:0] alu_val;
  logic         ld_valid;
  logic         ld_ready;
  logic [4:0]   ld_rd;
  logic [W-1:0] ld_val;
  logic         iss_valid;
  logic [4:0]   iss_rd;
  logic [4:0]   rs1_q;
  logic [4:0]   rs2_q;
  logic [4:0]   rd_q;
  logic         rs1_busy;
  logic         rs2_busy;
  logic         rd_busy;
  logic         w_enable;
  logic [4:0]   rd_select;
  logic [W-1:0] w_val;

  always #5 clk = ~clk;

  regfile_writer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_val(alu_val),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_rd(ld_rd), .ld_val(ld_val),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_q(rs1_q), .rs2_q(rs2_q), .rd_q(rd_q),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
    .w_enable(w_enable), .rd_select(rd_select), .w_val(w_val)
  );

  typedef struct {
    logic [4:0]   rd;
    logic [W-1:0] v;
  } ent_t;

  ent_t         q[$];
  bit           busy_m[32];
  logic         m_we;
  logic [4:0]   m_rs;
  logic [W-1:0] m_wv;
  int           checks = 0;
  int           errors = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    alu_valid = 0; alu_rd = 0; alu_val = 0;
    ld_valid = 0; ld_rd = 0; ld_val = 0;
    iss_valid = 0; iss_rd = 0;
    rs1_q = 0; rs2_q = 0; rd_q = 0;
  endtask

  task automatic model_reset();
    q.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    m_we = 0; m_rs = 0; m_wv = 0;
  endtask

  task automatic check_comb();
    #1;
    check("ld_ready", ld_ready, q.size() != D);
    check("rs1_busy", rs1_busy, busy_m[rs1_q]);
    check("rs2_busy", rs2_busy, busy_m[rs2_q]);
    check("rd_busy", rd_busy, busy_m[rd_q]);
  endtask

  task automatic step();
    bit   full;
    bit   sv;
    ent_t s;
    check_comb();
    full = (q.size() == D);
    sv = 0;
    s = '{rd: 0, v: 0};
    if (alu_valid) begin
      s = '{rd: alu_rd, v: alu_val};
      sv = 1;
    end else if (q.size() > 0) begin
      s = q.pop_front();
      sv = 1;
    end
    if (ld_valid && !full)
      q.push_back('{rd: ld_rd, v: ld_val});
    if (sv) busy_m[s.rd] = 0;
    if (iss_valid && iss_rd != 0) busy_m[iss_rd] = 1;
    m_we = sv && (s.rd != 0);
    if (m_we) begin
      m_rs = s.rd;
      m_wv = s.v;
    end
    @(posedge clk);
    #1;
    check("w_enable", w_enable, m_we);
    check("rd_select", rd_select, m_rs);
    check("w_val", w_val, m_wv);
  endtask

  task automatic load(input logic [4:0] rd, input logic [W-1:0] v);
    ld_valid = 1; ld_rd = rd; ld_val = v;
  endtask

  initial begin
    rst_n = 0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_we", w_enable, 0);
    check("rst_rs", rd_select, 0);
    check("rst_wv", w_val, 0);
    check("rst_ready", ld_ready, 1);
    rst_n = 1;

    // ALU path
    idle();
    alu_valid = 1; alu_rd = 7; alu_val = 32'hDEADBEEF;
    step();
    check("alu_we", w_enable, 1);
    check("alu_rs", rd_select, 7);
    check("alu_wv", w_val, 32'hDEADBEEF);
    idle();
    step();
    check("alu_we_off", w_enable, 0);

    // Scoreboard set / clear / set-wins
    idle(); iss_valid = 1; iss_rd = 9;
    step();
    idle(); rs1_q = 9; #1;
    check("sb_set", rs1_busy, 1);
    alu_valid = 1; alu_rd = 9; alu_val = 32'h99;
    step();
    idle(); rs1_q = 9; #1;
    check("sb_clr", rs1_busy, 0);
    alu_valid = 1; alu_rd = 9; alu_val = 32'h98;
    iss_valid = 1; iss_rd = 9;
    step();
    idle(); rs1_q = 9; #1;
    check("sb_setwins", rs1_busy, 1);
    alu_valid = 1; alu_rd = 9;
    step();

    // x0 handling
    idle();
    alu_valid = 1; alu_rd = 0; alu_val = 32'h55;
    iss_valid = 1; iss_rd = 0; rd_q = 0;
    step();
    check("x0_we", w_enable, 0);
    idle(); rd_q = 0; #1;
    check("x0_busy", rd_busy, 0);

    // Priority / fill: ALU holds the port for 6 cycles
    for (int i = 0; i < 6; i++) begin
      idle();
      alu_valid = 1; alu_rd = 5'(20 + i); alu_val = W'(32'h100 + i);
      if (i == 0) load(3, 32'h11);
      else if (i < 4) load(5'(3 + i), W'(32'h11 + i));
      if (i == 4) begin
        #1;
        check("fill_full", ld_ready, 0);
      end
      step();
    end
    // Drain; a push offered while full and popping is refused
    idle(); load(12, 32'hAA);
    check("fill_hold", ld_ready, 0);
    step();
    check("drain_first", rd_select, 3);
    idle(); load(12, 32'hAA);
    step();
    for (int i = 0; i < 5; i++) begin
      idle();
      step();
    end
    check("drain_ready", ld_ready, 1);

    // Wrap ordering over 2*DEPTH back-to-back loads
    for (int i = 0; i < 2 * D; i++) begin
      idle(); load(5'(1 + i), W'(32'hC0DE0000 + i));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      step();
    end

    // Reset mid-stream with queued loads and busy[5]
    for (int i = 0; i < 3; i++) begin
      idle();
      alu_valid = 1; alu_rd = 1; alu_val = W'(i);
      load(5'(10 + i), W'(32'hB0 + i));
      if (i == 0) begin iss_valid = 1; iss_rd = 5; end
      step();
    end
    idle(); rs1_q = 5; #1;
    check("pre_rst_busy", rs1_busy, 1);
    #1 rst_n = 0;
    #1;
    model_reset();
    check("mid_rst_we", w_enable, 0);
    check("mid_rst_busy", rs1_busy, 0);
    check("mid_rst_ready", ld_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      idle();
      step();
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      idle();
      alu_valid = ($urandom_range(0, 9) < 3);
      alu_rd    = 5'($urandom_range(0, 31));
      alu_val   = $urandom;
      ld_valid  = ($urandom_range(0, 9) < 6);
      ld_rd     = 5'($urandom_range(0, 31));
      ld_val    = $urandom;
      iss_valid = ($urandom_range(0, 9) < 5);
      iss_rd    = 5'($urandom_range(0, 31));
      rs1_q     = 5'($urandom_range(0, 31));
      rs2_q     = 5'($urandom_range(0, 31));
      rd_q      = 5'($urandom_range(0, 31));
      step();
    end
    for (int i = 0; i < D + 2; i++) begin
      idle();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
